// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Counts BUSY cycles; expired_o flags the TIMEOUT-th cycle so the FSM can abort at its end.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    // Saturates at TIMEOUT so a late m_ready can never wrap the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF (instruction fetch) and MEM (load/store) stages.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              flush,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_stall,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              err
);

    arb_state_e        state_q;
    logic              owner_q;
    logic              drop_q;
    logic              m_req_q;
    logic              m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [DATA_W-1:0] m_wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic busy;
    logic wd_expired;
    logic i_elig;
    logic d_elig;

    assign busy   = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
    assign d_elig = d_req && !d_valid;
    assign i_elig = if_req && !if_valid;

    arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!busy),
        .enable_i  (busy),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_I;
            drop_q    <= 1'b0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ARB_IDLE: begin
                    drop_q <= 1'b0;
                    // The MEM-stage instruction is older, so data has priority.
                    if (d_elig) begin
                        m_we_q    <= d_we;
                        m_addr_q  <= d_addr;
                        m_wdata_q <= d_wdata;
                        owner_q   <= OWN_D;
                        m_req_q   <= 1'b1;
                        state_q   <= ARB_BUSY_D;
                    end else if (i_elig) begin
                        m_we_q    <= 1'b0;
                        m_addr_q  <= if_addr;
                        m_wdata_q <= '0;
                        owner_q   <= OWN_I;
                        m_req_q   <= 1'b1;
                        state_q   <= ARB_BUSY_I;
                    end
                end
                ARB_BUSY_I, ARB_BUSY_D: begin
                    if ((state_q == ARB_BUSY_I) && flush) begin
                        drop_q <= 1'b1;
                    end
                    // A response arriving on the timeout cycle still completes normally.
                    if (m_ready) begin
                        rdata_q <= m_rdata;
                        m_req_q <= 1'b0;
                        state_q <= ARB_RESP;
                    end else if (wd_expired) begin
                        err_q   <= 1'b1;
                        m_req_q <= 1'b0;
                        drop_q  <= 1'b0;
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_RESP: begin
                    drop_q  <= 1'b0;
                    state_q <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    // Flush in RESP must kill the fetch pulse in the same cycle, hence the combinational term.
    assign if_valid  = (state_q == ARB_RESP) && (owner_q == OWN_I) && !drop_q && !flush;
    assign d_valid   = (state_q == ARB_RESP) && (owner_q == OWN_D);
    assign if_rdata  = rdata_q;
    assign d_rdata   = rdata_q;
    assign if_stall  = if_req && !if_valid;
    assign mem_stall = d_req && !d_valid;
    assign m_req     = m_req_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: vector table plus hand sequences, valids checked against a scoreboard queue.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, flush, d_req, d_we, m_ready;
    logic [31:0] if_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
    logic        if_valid, if_stall, d_valid, mem_stall, m_req, m_we, err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int mem_lat  = 1;
    int mem_cnt  = 0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;

    typedef struct {
        logic        own;
        logic        chk;
        logic [31:0] data;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_cyc;
    } vec_t;
    vec_t vecs[6];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_valid(if_valid), .if_stall(if_stall), .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .mem_stall(mem_stall),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h40) return 32'h00A00093;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Memory model: responds mem_lat cycles into a request (0 = never).
    always @(posedge clk) begin
        #1;
        if (m_req) begin
            mem_cnt++;
            m_ready = (mem_lat != 0) && (mem_cnt == mem_lat);
            m_rdata = m_ready ? mem_fn(m_addr) : 32'h0BAD0BAD;
            if (m_ready && m_we) begin
                wr_addr = m_addr;
                wr_data = m_wdata;
            end
        end else begin
            mem_cnt = 0;
            m_ready = 1'b0;
        end
    end

    task automatic sb_pop(input logic own, input logic [31:0] data);
        sb_t e;
        if (sbq.size() == 0) begin
            check("sb_unexpected_valid", {63'd0, own}, 64'h2);
        end else begin
            e = sbq.pop_front();
            check("sb_owner", {63'd0, own}, {63'd0, e.own});
            if (e.chk) check("sb_rdata", {32'd0, data}, {32'd0, e.data});
        end
    endtask

    always @(negedge clk) begin
        if (if_valid) sb_pop(1'b0, if_rdata);
        if (d_valid)  sb_pop(1'b1, d_rdata);
        if (err)      err_cnt++;
    end

    task automatic run_vec(input vec_t v, input int idx);
        int vcyc;
        tick();
        mem_lat = v.lat;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        sbq.push_back('{v.is_d, !v.we, mem_fn(v.addr)});
        #1;
        check($sformatf("v%0d_stall_c0", idx), {63'd0, v.is_d ? mem_stall : if_stall}, 64'd1);
        vcyc = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            #1;
            if (v.is_d ? d_valid : if_valid) begin
                vcyc = n;
                check($sformatf("v%0d_stall_done", idx), {63'd0, v.is_d ? mem_stall : if_stall}, 64'd0);
                check($sformatf("v%0d_mreq_done", idx), {63'd0, m_req}, 64'd0);
                break;
            end
            check($sformatf("v%0d_stall_c%0d", idx, n), {63'd0, v.is_d ? mem_stall : if_stall}, 64'd1);
            check($sformatf("v%0d_mreq_c%0d", idx, n), {63'd0, m_req}, 64'd1);
            check($sformatf("v%0d_mwe_c%0d", idx, n), {63'd0, m_we}, {63'd0, v.we});
            check($sformatf("v%0d_maddr_c%0d", idx, n), {32'd0, m_addr}, {32'd0, v.addr});
            if (v.we) check($sformatf("v%0d_mwdata_c%0d", idx, n), {32'd0, m_wdata}, {32'd0, v.wdata});
        end
        check($sformatf("v%0d_latency", idx), 64'(vcyc), 64'(v.exp_cyc));
        tick();
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int dcyc, icyc, ecyc, vcyc;
        logic bad;
        rst_n = 1'b0; if_req = 1'b0; flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; m_ready = 1'b0; m_rdata = '0;

        vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        2,  3};
        vecs[1] = '{1'b0, 1'b0, 32'h44,  32'h0,        1,  2};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        1,  2};
        vecs[3] = '{1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 3,  4};
        vecs[4] = '{1'b1, 1'b0, 32'h104, 32'h0,        5,  6};
        vecs[5] = '{1'b0, 1'b0, 32'h48,  32'h0,        15, 16};

        repeat (2) @(posedge clk);
        #3;
        check("rst_mreq",   {63'd0, m_req}, 64'd0);
        check("rst_mwe",    {63'd0, m_we}, 64'd0);
        check("rst_maddr",  {32'd0, m_addr}, 64'd0);
        check("rst_mwdata", {32'd0, m_wdata}, 64'd0);
        check("rst_valids", {62'd0, if_valid, d_valid}, 64'd0);
        check("rst_rdata",  {if_rdata, d_rdata}, 64'd0);
        check("rst_err",    {63'd0, err}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            if (vecs[i].we) begin
                check("store_wr_addr", {32'd0, wr_addr}, {32'd0, vecs[i].addr});
                check("store_wr_data", {32'd0, wr_data}, {32'd0, vecs[i].wdata});
            end
        end
        check("no_err_after_table", 64'(err_cnt), 64'd0);

        // Simultaneous requests: data first, fetch three cycles later.
        tick();
        mem_lat = 1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h60;
        sbq.push_back('{1'b1, 1'b1, mem_fn(32'h100)});
        sbq.push_back('{1'b0, 1'b1, mem_fn(32'h60)});
        dcyc = -1; icyc = -1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (dcyc >= 0 && dcyc == n - 1) d_req = 1'b0;
            #1;
            if (n == 1) check("both_first_addr", {32'd0, m_addr}, 64'h100);
            if (d_valid) begin
                dcyc = n;
                check("both_memstall_at_dvalid", {63'd0, mem_stall}, 64'd0);
                check("both_ifstall_at_dvalid", {63'd0, if_stall}, 64'd1);
            end
            if (if_valid) begin
                icyc = n;
                break;
            end
        end
        check("both_dvalid_cycle", 64'(dcyc), 64'd2);
        check("both_ivalid_cycle", 64'(icyc), 64'd5);
        tick();
        if_req = 1'b0; d_req = 1'b0;

        // Flush during BUSY_I: old fetch discarded, redirected fetch served.
        tick();
        mem_lat = 3;
        if_req = 1'b1; if_addr = 32'h80;
        sbq.push_back('{1'b0, 1'b1, mem_fn(32'h90)});
        tick();
        flush = 1'b1; if_addr = 32'h90;
        #1;
        check("flush_addr_held", {32'd0, m_addr}, 64'h80);
        tick();
        flush = 1'b0;
        icyc = -1;
        for (int n = 2; n <= 20; n++) begin
            if (n > 2) tick();
            #1;
            if (if_valid) begin
                icyc = n;
                break;
            end
        end
        check("flush_next_valid_cycle", 64'(icyc), 64'd9);
        tick();
        if_req = 1'b0;

        // Watchdog abort and re-issue of the still-held load.
        tick();
        mem_lat = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        sbq.push_back('{1'b1, 1'b1, mem_fn(32'h300)});
        ecyc = -1; vcyc = -1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n == 16) mem_lat = 2;
            #1;
            if (err && ecyc < 0) begin
                ecyc = n;
                check("to_mreq_dropped", {63'd0, m_req}, 64'd0);
                check("to_no_valid", {62'd0, d_valid, if_valid}, 64'd0);
                check("to_still_stalled", {63'd0, mem_stall}, 64'd1);
            end
            if (n == 17) check("to_reissue", {63'd0, m_req}, 64'd1);
            if (d_valid) begin
                vcyc = n;
                break;
            end
        end
        check("to_err_cycle", 64'(ecyc), 64'd16);
        check("to_valid_cycle", 64'(vcyc), 64'd19);
        check("to_err_once", 64'(err_cnt), 64'd1);
        tick();
        d_req = 1'b0;

        // Reset in BUSY_D: m_req drops at once, no stale completion afterwards.
        tick();
        mem_lat = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h12345678;
        tick();
        tick();
        #1;
        check("rst_mid_busy", {63'd0, m_req}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_mreq_async", {63'd0, m_req}, 64'd0);
        check("rst_mid_mwe_async", {63'd0, m_we}, 64'd0);
        d_req = 1'b0;
        tick();
        rst_n = 1'b1;
        bad = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            #1;
            bad = bad | d_valid | m_req | err;
        end
        check("rst_mid_no_stale", {63'd0, bad}, 64'd0);
        run_vec(vecs[1], 6);

        tick();
        check("sb_drained", 64'(sbq.size()), 64'd0);
        check("err_total", 64'(err_cnt), 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
